lcd_frame_feeder: RTL and testbench

//  Upstream stage of the LCD control unit: a 32-char (2x16) frame buffer with a host write port.

---
 rtl/lcd_frame_feeder.sv | 188 ++++++++++++++++++
 tb/tb_lcd_frame_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_feeder.sv
// 2x16 LCD frame buffer with host write port; replays the whole frame as a valid/ready byte stream.
// Define LCD_FEEDER_AUTO_REFRESH_EN to add a free-running periodic refresh of REFRESH_CYCLES clocks.
module lcd_frame_feeder #(
  parameter int unsigned REFRESH_CYCLES = 2500000,
  parameter logic [7:0]  FILL_CHAR      = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh_req,
  input  logic       lcd_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_rs,
  output logic       busy,
  output logic       dirty,
  output logic       frame_done
);

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] CMD_LINE1 = 8'h80;
  localparam logic [DATA_W-1:0] CMD_LINE2 = 8'hC0;
  localparam logic [ADDR_W-1:0] LAST_L1   = 5'd15;
  localparam logic [ADDR_W-1:0] FIRST_L2  = 5'd16;
  localparam logic [ADDR_W-1:0] LAST_L2   = 5'd31;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD_L1 = 3'd1,
    CHR_L1 = 3'd2,
    CMD_L2 = 3'd3,
    CHR_L2 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] frame_buf [DEPTH];
  logic [ADDR_W-1:0] idx, idx_nxt, idx_inc;
  logic              out_valid_nxt, out_rs_nxt, busy_nxt, dirty_nxt, frame_done_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic              xfer;
  logic              refresh_tick;

  if (REFRESH_CYCLES == 0) begin : g_bad_period
    $error("REFRESH_CYCLES must be nonzero");
  end

  assign xfer    = out_valid & lcd_ready;
  assign idx_inc = idx + ADDR_W'(1);

`ifdef LCD_FEEDER_AUTO_REFRESH_EN
  localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] refresh_cnt;

  // Free-running period counter; its wrap marks the frame dirty.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  assign refresh_tick = (refresh_cnt == CNT_LAST);
`else
  assign refresh_tick = 1'b0;
`endif

  // Character storage; host writes land in any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        frame_buf[i] <= FILL_CHAR;
      end
    end else if (wr_en) begin
      frame_buf[wr_addr] <= wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_rs     <= 1'b0;
      busy       <= 1'b0;
      dirty      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_rs     <= out_rs_nxt;
      busy       <= busy_nxt;
      dirty      <= dirty_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  // Next-state sequencing of the 34-item frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dirty) state_nxt = CMD_L1;
      CMD_L1:  if (xfer) state_nxt = CHR_L1;
      CHR_L1:  if (xfer && idx == LAST_L1) state_nxt = CMD_L2;
      CMD_L2:  if (xfer) state_nxt = CHR_L2;
      CHR_L2:  if (xfer && idx == LAST_L2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values; a stalled item simply keeps its registers.
  always_comb begin
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_rs_nxt     = out_rs;
    idx_nxt        = idx;
    dirty_nxt      = dirty;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (dirty) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = CMD_LINE1;
          out_rs_nxt    = 1'b0;
          dirty_nxt     = 1'b0;
        end
      end
      CMD_L1: begin
        if (xfer) begin
          out_data_nxt = frame_buf[0];
          out_rs_nxt   = 1'b1;
          idx_nxt      = '0;
        end
      end
      CHR_L1: begin
        if (xfer) begin
          if (idx == LAST_L1) begin
            out_data_nxt = CMD_LINE2;
            out_rs_nxt   = 1'b0;
          end else begin
            idx_nxt      = idx_inc;
            out_data_nxt = frame_buf[idx_inc];
          end
        end
      end
      CMD_L2: begin
        if (xfer) begin
          out_data_nxt = frame_buf[FIRST_L2];
          out_rs_nxt   = 1'b1;
          idx_nxt      = FIRST_L2;
        end
      end
      CHR_L2: begin
        if (xfer) begin
          if (idx == LAST_L2) begin
            out_valid_nxt  = 1'b0;
            frame_done_nxt = 1'b1;
          end else begin
            idx_nxt      = idx_inc;
            out_data_nxt = frame_buf[idx_inc];
          end
        end
      end
      default: ;
    endcase
    // A new request in the start cycle must survive the clear above.
    if (wr_en || refresh_req || refresh_tick) begin
      dirty_nxt = 1'b1;
    end
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Self-checking bench for lcd_frame_feeder: per-cycle frame model plus directed literal checks.
`timescale 1ns/1ps
module tb_lcd_frame_feeder;

  localparam int unsigned REFRESH   = 100;
  localparam int          FRAME_LEN = 34;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       refresh_req = 1'b0;
  logic       lcd_ready = 1'b0;
  logic       out_valid, out_rs, busy, dirty, frame_done;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lcd_frame_feeder #(.REFRESH_CYCLES(REFRESH), .FILL_CHAR(8'h20)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh_req(refresh_req), .lcd_ready(lcd_ready), .out_valid(out_valid),
    .out_data(out_data), .out_rs(out_rs), .busy(busy), .dirty(dirty), .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is the fixed list of 34 items, indexed by transfer number.
  logic [7:0] mbuf [32];
  bit         m_valid, m_busy, m_dirty, m_done, m_rs;
  logic [7:0] m_data;
  int         m_t;
  int         m_cnt;

  function automatic logic [8:0] seq_item(input int t);
    if (t == 0)  return {1'b0, 8'h80};
    if (t <= 16) return {1'b1, mbuf[t-1]};
    if (t == 17) return {1'b0, 8'hC0};
    return {1'b1, mbuf[t-2]};
  endfunction

  always @(posedge clk) begin
    bit ev, at;
    if (reset) begin
      for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
      m_valid = 0; m_busy = 0; m_dirty = 0; m_done = 0; m_rs = 0; m_data = 8'h00; m_t = 0; m_cnt = 0;
    end else begin
`ifdef LCD_FEEDER_AUTO_REFRESH_EN
      at = (m_cnt == int'(REFRESH) - 1);
      m_cnt = at ? 0 : m_cnt + 1;
`else
      at = 1'b0;
`endif
      ev = wr_en | refresh_req | at;
      if (m_done) begin
        m_done = 0; m_busy = 0; m_dirty = m_dirty | ev;
      end else if (!m_busy) begin
        if (m_dirty) begin
          m_t = 0; {m_rs, m_data} = seq_item(0); m_valid = 1; m_busy = 1; m_dirty = ev;
        end else begin
          m_dirty = ev;
        end
      end else begin
        m_dirty = m_dirty | ev;
        if (m_valid && lcd_ready) begin
          m_t++;
          if (m_t == FRAME_LEN) begin
            m_valid = 0; m_done = 1;
          end else begin
            {m_rs, m_data} = seq_item(m_t);
          end
        end
      end
      if (wr_en) mbuf[wr_addr] = wr_data;
    end
  end

  // Transfer log and event counters, filled by the compare process.
  logic [8:0] xq [$];
  int         start_q [$];
  int         n_done = 0;
  int         cyc = 0;
  bit         dirty_at_done = 0;
  bit         pv = 0, pr = 0, prs = 0, pres = 1;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("dirty", 32'(dirty), 32'(m_dirty));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      if (out_valid && m_valid) begin
        chk("data", 32'(out_data), 32'(m_data));
        chk("rs", 32'(out_rs), 32'(m_rs));
      end
      if (pv && !pr && !pres) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'({out_rs, out_data}), 32'({prs, pd}));
      end
      if (out_valid && lcd_ready) xq.push_back({out_rs, out_data});
      if (out_valid && !pv) start_q.push_back(cyc);
      if (frame_done) begin
        n_done++;
        dirty_at_done = dirty;
      end
      pv = out_valid; pr = lcd_ready; pd = out_data; prs = out_rs; pres = reset;
    end
  end

  int log_base = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    log_base = xq.size();
  endtask

  function automatic int logged();
    return xq.size() - log_base;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, 32'(n_done != start), 32'd1);
  endtask

  // Compares the logged frame against the literal all-space frame with up to two char overrides.
  task automatic chk_frame(input string name, input int o1, input logic [7:0] v1,
                           input int o2, input logic [7:0] v2);
    logic [8:0] e;
    int bad = 0;
    chk({name, "_len"}, 32'(logged()), 32'(FRAME_LEN));
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == 0)       e = 9'h080;
      else if (i == 17) e = 9'h0C0;
      else              e = 9'h120;
      if (i == o1) e = {1'b1, v1};
      if (i == o2) e = {1'b1, v2};
      if (log_base + i >= xq.size() || xq[log_base + i] !== e) bad++;
    end
    chk({name, "_items_wrong"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int k, s;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s;
    reset = 1; lcd_ready = 1;
    @(posedge clk); #1;
    chk_en = 1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 0;
    tick();

    // Test 1: one refresh pulse gives the blank frame.
    clear_log();
    refresh_req = 1; tick(); refresh_req = 0;
    chk("t1_dirty_latency", 32'(dirty), 32'd1);
    tick();
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_item", 32'({out_rs, out_data}), 32'h080);
    s = n_done;
    wait_done("t1", 200);
    chk("t1_busy_after", 32'(busy), 32'd0);
    chk_frame("t1", -1, 8'h00, -1, 8'h00);
    repeat (5) tick();
    chk("t1_done_pulses", 32'(n_done - s), 32'd1);

    // Test 2: writes start a frame; both written chars are picked up.
    clear_log();
    wr_en = 1; wr_addr = 5'd0;  wr_data = 8'h48; tick();
    wr_addr = 5'd17; wr_data = 8'h45; tick();
    wr_en = 0;
    wait_done("t2a", 200);
    chk_frame("t2a", 1, 8'h48, 19, 8'h45);
    chk("t2_dirty_at_done", 32'(dirty_at_done), 32'd1);
    clear_log();
    wait_done("t2b", 200);
    chk_frame("t2b", 1, 8'h48, 19, 8'h45);
    tick();
    chk("t2_idle_clean", 32'(dirty), 32'd0);

    // Test 3: ready one cycle in four; reset first restores the blank buffer.
    reset = 1; tick(); reset = 0;
    clear_log();
    lcd_ready = 0;
    refresh_req = 1; tick(); refresh_req = 0;
    s = n_done; k = 0;
    while (n_done == s && k < 600) begin
      lcd_ready = (k % 4 == 3);
      tick();
      k++;
    end
    lcd_ready = 1;
    chk("t3_done_seen", 32'(n_done != s), 32'd1);
    chk_frame("t3", -1, 8'h00, -1, 8'h00);

    // Test 4: write to an already-sent entry lands in the following frame.
    tick();
    clear_log();
    refresh_req = 1; tick(); refresh_req = 0;
    k = 0;
    while (logged() < 5 && k < 100) begin tick(); k++; end
    chk("t4_reached_5", 32'(logged() >= 5), 32'd1);
    wr_en = 1; wr_addr = 5'd3; wr_data = 8'h41; tick(); wr_en = 0;
    wait_done("t4a", 200);
    chk_frame("t4a", -1, 8'h00, -1, 8'h00);
    chk("t4_dirty_at_done", 32'(dirty_at_done), 32'd1);
    clear_log();
    wait_done("t4b", 200);
    chk_frame("t4b", 4, 8'h41, -1, 8'h00);

    // Test 5: reset in the middle of line 2 aborts and restores the fill.
    tick();
    clear_log();
    refresh_req = 1; tick(); refresh_req = 0;
    k = 0;
    while (logged() < 20 && k < 100) begin tick(); k++; end
    chk("t5_in_line2", 32'(logged() >= 20), 32'd1);
    reset = 1; tick(); reset = 0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_dirty", 32'(dirty), 32'd0);
    chk("t5_done", 32'(frame_done), 32'd0);
    clear_log();
    refresh_req = 1; tick(); refresh_req = 0;
    wait_done("t5", 200);
    chk_frame("t5", -1, 8'h00, -1, 8'h00);

    // Test 6: periodic refresh only when the feature is built in.
    reset = 1; tick(); reset = 0;
    s = start_q.size();
`ifdef LCD_FEEDER_AUTO_REFRESH_EN
    repeat (350) tick();
    chk("t6_starts", 32'(start_q.size() - s), 32'd3);
    if (start_q.size() >= s + 3) begin
      chk("t6_period_a", 32'(start_q[s+1] - start_q[s]), 32'd100);
      chk("t6_period_b", 32'(start_q[s+2] - start_q[s+1]), 32'd100);
    end
`else
    repeat (1000) tick();
    chk("t6_no_frames", 32'(start_q.size() - s), 32'd0);
    chk("t6_still_idle", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
